// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: channel FSM encoding and default build parameters.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } ch_state_e;

  localparam int NCH_DEF        = 4;
  localparam int DIV_DEF        = 4;
  localparam int HOLD_TICKS_DEF = 3;
  localparam int GAP_TICKS_DEF  = 1;
  localparam int Q_W_DEF        = 2;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event-in / level-out bundle of the pulse stretcher; master drives events, slave is the stretcher.
interface pulse_stretcher_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0] pulse_in;
  logic           clr_ovf;
  logic [NCH-1:0] level_out;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] ovf;

  modport master (
    output pulse_in, clr_ovf,
    input  level_out, busy, ovf
  );

  modport slave (
    input  pulse_in, clr_ovf,
    output level_out, busy, ovf
  );
endinterface

// File: rtl/pulse_stretch_ch.sv
// One stretcher channel: saturating pending-event counter, IDLE/HOLD/GAP window FSM and sticky overflow.
module pulse_stretch_ch
  import pulse_stretcher_pkg::*;
#(
  parameter int HOLD_TICKS = HOLD_TICKS_DEF,
  parameter int GAP_TICKS  = GAP_TICKS_DEF,
  parameter int Q_W        = Q_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pulse,
  input  logic clr_ovf,
  output logic level,
  output logic busy,
  output logic ovf
);

  localparam int TCNT_W = $clog2(max_i(HOLD_TICKS, GAP_TICKS) + 1);
  localparam logic [TCNT_W-1:0] TCNT_ONE = TCNT_W'(1);
  localparam logic [Q_W-1:0]    PEND_ONE = Q_W'(1);
  localparam logic [Q_W-1:0]    PEND_MAX = '1;

  ch_state_e         state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [Q_W-1:0]    pend_q;
  logic              ovf_q;
  logic              deq;
  logic              drop;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    deq     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q != '0) begin
          deq     = 1'b1;
          tcnt_d  = TCNT_W'(HOLD_TICKS);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          if (tcnt_q == TCNT_ONE) begin
            // A zero gap returns straight to IDLE so a queued event restarts one cycle later.
            if (GAP_TICKS == 0) begin
              state_d = ST_IDLE;
            end else begin
              tcnt_d  = TCNT_W'(GAP_TICKS);
              state_d = ST_GAP;
            end
          end else begin
            tcnt_d = tcnt_q - TCNT_ONE;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (tcnt_q == TCNT_ONE) begin
            state_d = ST_IDLE;
          end else begin
            tcnt_d = tcnt_q - TCNT_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // A full queue still accepts an event when a dequeue frees a slot the same cycle.
  assign drop = pulse && !deq && (pend_q == PEND_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else if (pulse && !deq && !drop) begin
      pend_q <= pend_q + PEND_ONE;
    end else if (deq && !pulse) begin
      pend_q <= pend_q - PEND_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign level = (state_q == ST_HOLD);
  assign busy  = (state_q != ST_IDLE) || (pend_q != '0);
  assign ovf   = ovf_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Multi-channel pulse stretcher: shared tick prescaler feeding NCH independent stretcher channels.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int DIV        = DIV_DEF,
  parameter int HOLD_TICKS = HOLD_TICKS_DEF,
  parameter int GAP_TICKS  = GAP_TICKS_DEF,
  parameter int Q_W        = Q_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  pulse_stretcher_if.slave bus
);

  localparam int PS_W = $clog2(DIV);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  logic [PS_W-1:0] ps_q;
  logic            tick;

  assign tick = (ps_q == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q <= '0;
    end else if (tick) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_q + PS_ONE;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pulse_stretch_ch #(
      .HOLD_TICKS (HOLD_TICKS),
      .GAP_TICKS  (GAP_TICKS),
      .Q_W        (Q_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .pulse   (bus.pulse_in[i]),
      .clr_ovf (bus.clr_ovf),
      .level   (bus.level_out[i]),
      .busy    (bus.busy[i]),
      .ovf     (bus.ovf[i])
    );
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: default build and a zero-gap build driven with identical stimulus,
// checked every cycle against a window-schedule model plus hand-computed cycle pins.
module tb_pulse_stretcher;

  localparam int NCH  = 4;
  localparam int DIV  = 4;
  localparam int H    = 3;
  localparam int G    = 1;
  localparam int QW   = 2;
  localparam int QMAX = 3;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic [NCH-1:0] pulse = '0;
  logic           clr   = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pulse_stretcher_if #(.NCH(NCH)) bus_a ();
  pulse_stretcher_if #(.NCH(NCH)) bus_b ();

  assign bus_a.pulse_in = pulse;
  assign bus_a.clr_ovf  = clr;
  assign bus_b.pulse_in = pulse;
  assign bus_b.clr_ovf  = clr;

  pulse_stretcher #(.NCH(NCH), .DIV(DIV), .HOLD_TICKS(H), .GAP_TICKS(G), .Q_W(QW)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  pulse_stretcher #(.NCH(NCH), .DIV(DIV), .HOLD_TICKS(H), .GAP_TICKS(0), .Q_W(QW)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // Model: per instance/channel a pending count and the cycle span of the current window.
  int mcyc;
  int m_pend [2][NCH];
  int m_hs   [2][NCH];
  int m_he   [2][NCH];
  int m_idle [2][NCH];
  bit m_ovf  [2][NCH];

  function automatic int tick_n(input int s, input int n);
    return s + (DIV - 1 - (s % DIV)) + (n - 1) * DIV;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, mcyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mcyc = 0;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NCH; c++) begin
        m_pend[k][c] = 0; m_hs[k][c] = 0; m_he[k][c] = -1;
        m_idle[k][c] = 0; m_ovf[k][c] = 1'b0;
      end
  endtask

  task automatic compare_model();
    logic [NCH-1:0] el, eb, eo, al, ab, ao;
    int g, hs, he;
    bit deq, drop, p;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NCH; c++) begin
        el[c] = (mcyc >= m_hs[k][c]) && (mcyc <= m_he[k][c]);
        eb[c] = ((mcyc >= m_hs[k][c]) && (mcyc < m_idle[k][c])) || (m_pend[k][c] > 0);
        eo[c] = m_ovf[k][c];
      end
      al = (k == 0) ? bus_a.level_out : bus_b.level_out;
      ab = (k == 0) ? bus_a.busy      : bus_b.busy;
      ao = (k == 0) ? bus_a.ovf       : bus_b.ovf;
      check($sformatf("model_level_%0d", k), int'(al), int'(el));
      check($sformatf("model_busy_%0d", k),  int'(ab), int'(eb));
      check($sformatf("model_ovf_%0d", k),   int'(ao), int'(eo));
    end
    for (int k = 0; k < 2; k++) begin
      g = (k == 0) ? G : 0;
      for (int c = 0; c < NCH; c++) begin
        p    = pulse[c];
        deq  = (mcyc >= m_idle[k][c]) && (m_pend[k][c] > 0);
        drop = p && !deq && (m_pend[k][c] == QMAX);
        if (deq) begin
          hs = mcyc + 1;
          he = tick_n(hs, H);
          m_hs[k][c]   = hs;
          m_he[k][c]   = he;
          m_idle[k][c] = (g == 0) ? he + 1 : tick_n(he + 1, g) + 1;
        end
        if (p && !deq && !drop) m_pend[k][c]++;
        else if (deq && !p)     m_pend[k][c]--;
        if (drop)     m_ovf[k][c] = 1'b1;
        else if (clr) m_ovf[k][c] = 1'b0;
      end
    end
  endtask

  // Compare at the falling edge, then move to the start of the next cycle with inputs cleared.
  task automatic step();
    @(negedge clk);
    if (!rst_n) begin
      check("rst_level_a", int'(bus_a.level_out), 0);
      check("rst_busy_a",  int'(bus_a.busy),      0);
      check("rst_ovf_a",   int'(bus_a.ovf),       0);
      check("rst_busy_b",  int'(bus_b.busy),      0);
      model_reset();
    end else begin
      compare_model();
      mcyc++;
    end
    @(posedge clk);
    #1;
    pulse = '0;
    clr   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev;
    int   rises;
    model_reset();
    #1;
    do_reset();

    // Single pulse on ch0
    while (mcyc < 40) begin
      if (mcyc == 10) pulse[0] = 1'b1;
      case (mcyc)
        11: check("t1_lvl_11", int'(bus_a.level_out[0]), 0);
        12: begin
          check("t1_lvl_12", int'(bus_a.level_out[0]), 1);
          check("t1_others_12", int'(bus_a.level_out[3:1]), 0);
        end
        23: begin
          check("t1_lvl_23", int'(bus_a.level_out[0]), 1);
          check("t1_busy_b_23", int'(bus_b.busy[0]), 1);
        end
        24: begin
          check("t1_lvl_24", int'(bus_a.level_out[0]), 0);
          check("t1_busy_b_24", int'(bus_b.busy[0]), 0);
        end
        27: check("t1_busy_27", int'(bus_a.busy[0]), 1);
        28: check("t1_busy_28", int'(bus_a.busy[0]), 0);
        default: ;
      endcase
      step();
    end

    // Three back-to-back pulses on ch0
    do_reset();
    while (mcyc < 70) begin
      if (mcyc >= 10 && mcyc <= 12) pulse[0] = 1'b1;
      case (mcyc)
        24: check("t2_lvl_b_24", int'(bus_b.level_out[0]), 0);
        25: check("t2_lvl_b_25", int'(bus_b.level_out[0]), 1);
        28: check("t2_lvl_28", int'(bus_a.level_out[0]), 0);
        29: check("t2_lvl_29", int'(bus_a.level_out[0]), 1);
        39: check("t2_lvl_39", int'(bus_a.level_out[0]), 1);
        40: check("t2_lvl_40", int'(bus_a.level_out[0]), 0);
        45: check("t2_lvl_45", int'(bus_a.level_out[0]), 1);
        55: check("t2_lvl_55", int'(bus_a.level_out[0]), 1);
        56: check("t2_lvl_56", int'(bus_a.level_out[0]), 0);
        59: check("t2_busy_59", int'(bus_a.busy[0]), 1);
        60: begin
          check("t2_busy_60", int'(bus_a.busy[0]), 0);
          check("t2_ovf_60", int'(bus_a.ovf[0]), 0);
        end
        default: ;
      endcase
      step();
    end

    // Queue overflow on ch1, clear, then clear coincident with a drop
    do_reset();
    prev  = 1'b0;
    rises = 0;
    while (mcyc < 100) begin
      if (mcyc >= 10 && mcyc <= 14) pulse[1] = 1'b1;
      if (mcyc >= 82 && mcyc <= 86) pulse[1] = 1'b1;
      if (mcyc == 80 || mcyc == 86) clr = 1'b1;
      if (mcyc < 80 && bus_a.level_out[1] && !prev) rises++;
      prev = bus_a.level_out[1];
      case (mcyc)
        14: check("t3_ovf_14", int'(bus_a.ovf[1]), 0);
        15: check("t3_ovf_15", int'(bus_a.ovf[1]), 1);
        80: begin
          check("t3_windows", rises, 4);
          check("t3_ovf_80", int'(bus_a.ovf[1]), 1);
        end
        81: check("t3_ovf_81", int'(bus_a.ovf[1]), 0);
        86: check("t3_ovf_86", int'(bus_a.ovf[1]), 0);
        87: check("t3_ovf_87", int'(bus_a.ovf[1]), 1);
        default: ;
      endcase
      step();
    end

    // Asynchronous reset in the middle of a window
    do_reset();
    while (mcyc < 18) begin
      if (mcyc == 10) pulse[0] = 1'b1;
      if (mcyc >= 2 && mcyc <= 6) pulse[2] = 1'b1;
      if (mcyc == 17) begin
        check("t4_lvl_17", int'(bus_a.level_out[0]), 1);
        check("t4_ovf_17", int'(bus_a.ovf[2]), 1);
      end
      step();
    end
    rst_n = 1'b0;
    #1;
    check("t4_rst_level", int'(bus_a.level_out), 0);
    check("t4_rst_busy",  int'(bus_a.busy), 0);
    check("t4_rst_ovf",   int'(bus_a.ovf), 0);
    step();
    step();
    rst_n = 1'b1;
    while (mcyc < 30) begin
      if (mcyc == 2 || mcyc == 15) begin
        check("t4_post_level", int'(bus_a.level_out), 0);
        check("t4_post_busy",  int'(bus_a.busy), 0);
      end
      step();
    end

    // All channels at once
    do_reset();
    while (mcyc < 40) begin
      if (mcyc == 10) pulse = '1;
      case (mcyc)
        12: check("t5_lvl_12", int'(bus_a.level_out), 15);
        23: check("t5_lvl_23", int'(bus_a.level_out), 15);
        24: begin
          check("t5_lvl_24", int'(bus_a.level_out), 0);
          check("t5_busy_b_24", int'(bus_b.busy), 0);
        end
        default: ;
      endcase
      step();
    end

    // Randomised traffic with varying density, clears and occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int dens;
      dens = (i / 500) % 3 + 1;
      for (int c = 0; c < NCH; c++)
        pulse[c] = ($urandom_range(0, 7) < dens);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      if (!rst_n && $urandom_range(0, 1) == 0) rst_n = 1'b1;
      step();
    end
    rst_n = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
